// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter command sequencer.
//   cmd_t   : command encoding carried on req_cmd (CLEAR/LOAD/UP/DOWN)
//   state_t : sequencer FSM states
//   MAX_REQ : largest supported requester count
//   idx_width(): width of an index into n requesters (at least 1 bit)
package counter_seq_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned CMD_W   = 2;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_UP    = 2'b10,
    CMD_DOWN  = 2'b11
  } cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches valid starting one slot after ptr, wrapping
// modulo N, and reports the first hit.
//   valid   in  N      request vector
//   ptr     in  IDX_W  last granted index
//   grant_c out N      one-hot grant (zero when nothing valid)
//   index_c out IDX_W  index of the granted requester
//   any_c   out 1      at least one request valid
module rr_arbiter
  import counter_seq_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] index_c,
  output logic             any_c
);

  int unsigned  pos;
  logic [N-1:0] rot;

  // Walk ptr+1, ptr+2, ... ptr+N (mod N); the first valid slot wins.
  always_comb begin
    index_c = '0;
    any_c   = 1'b0;
    pos     = 0;
    rot     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      pos = (32'(ptr) + i) % N;
      rot = valid >> pos;
      if (!any_c && rot[0]) begin
        any_c   = 1'b1;
        index_c = IDX_W'(pos);
      end
    end
    grant_c = any_c ? (N'(1) << index_c) : '0;
  end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Shared up/down counter with a round-robin command sequencer.
// N_REQ requesters plus an internal prescaler tick (auto-count) issue
// CLEAR/LOAD/UP/DOWN commands; one command executes at a time (IDLE grant,
// EXEC update) and status pulses are registered alongside the new count.
// Build option: define COUNT_SAT_EN to make UP/DOWN saturate instead of wrap.
// Ports:
//   sys_clk, reset       clock, synchronous active-high reset
//   enable               allow new grants
//   req_valid/cmd/data   per-requester command interface, req_ready accept pulse
//   autocount            prescaler ticks issue implicit UP commands
//   tick_period          prescaler reload (tick every tick_period+1 cycles)
//   match_value          compare value for evt_match
//   count, busy          counter value, EXEC indicator
//   evt_zero/match/wrap/overrun  one-cycle status pulses
module counter_cmd_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 24
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [CMD_W*N_REQ-1:0]   req_cmd,
  input  logic [WIDTH*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     autocount,
  input  logic [DIV_W-1:0]         tick_period,
  input  logic [WIDTH-1:0]         match_value,
  output logic [WIDTH-1:0]         count,
  output logic                     busy,
  output logic                     evt_zero,
  output logic                     evt_match,
  output logic                     evt_wrap,
  output logic                     evt_overrun
);

  localparam int unsigned      IDX_W    = idx_width(N_REQ);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  cmd_t               cmd_q, cmd_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick_pend_q, tick_pend_d;
  logic               evt_zero_q, evt_zero_d;
  logic               evt_match_q, evt_match_d;
  logic               evt_wrap_q, evt_wrap_d;
  logic               evt_overrun_q, evt_overrun_d;

  logic               tick_c;
  logic               tick_take_c;
  logic               step_wrap_c;
  logic [WIDTH-1:0]   result_c;
  logic [N_REQ-1:0]   arb_grant_c;
  logic [IDX_W-1:0]   arb_idx_c;
  logic               arb_any_c;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .valid   (req_valid),
    .ptr     (rr_ptr_q),
    .grant_c (arb_grant_c),
    .index_c (arb_idx_c),
    .any_c   (arb_any_c)
  );

  // Prescaler: free-running down-counter, tick on the zero cycle.
  always_comb begin
    tick_c = (div_q == '0);
    div_d  = tick_c ? tick_period : div_q - DIV_W'(1);
  end

  // Sequencer FSM next-state, command latch and result/event evaluation.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    rr_ptr_d    = rr_ptr_q;
    req_ready   = '0;
    tick_take_c = 1'b0;
    step_wrap_c = 1'b0;
    result_c    = count_q;
    evt_zero_d  = 1'b0;
    evt_match_d = 1'b0;
    evt_wrap_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && !reset) begin
          if (arb_any_c) begin
            req_ready = arb_grant_c;
            cmd_d     = cmd_t'(CMD_W'(req_cmd >> (CMD_W * 32'(arb_idx_c))));
            data_d    = WIDTH'(req_data >> (WIDTH * 32'(arb_idx_c)));
            rr_ptr_d  = arb_idx_c;
            state_d   = ST_EXEC;
          end else if (tick_pend_q) begin
            // Auto-count only wins when no external requester is waiting.
            tick_take_c = 1'b1;
            cmd_d       = CMD_UP;
            data_d      = '0;
            state_d     = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        case (cmd_q)
          CMD_CLEAR: result_c = '0;
          CMD_LOAD:  result_c = data_q;
          CMD_UP: begin
            step_wrap_c = (count_q == ALL_ONES);
            result_c    = count_q + WIDTH'(1);
          end
          CMD_DOWN: begin
            step_wrap_c = (count_q == '0);
            result_c    = count_q - WIDTH'(1);
          end
          default: result_c = count_q;
        endcase
`ifdef COUNT_SAT_EN
        if (step_wrap_c) begin
          result_c = count_q;
        end
`endif
        count_d     = result_c;
        evt_zero_d  = (result_c == '0);
        evt_match_d = (result_c == match_value);
        evt_wrap_d  = step_wrap_c;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending auto-count tick; a second tick while one is still pending is dropped.
  always_comb begin
    tick_pend_d   = (tick_pend_q && !tick_take_c) || (tick_c && autocount);
    evt_overrun_d = tick_c && autocount && tick_pend_q && !tick_take_c;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      cmd_q         <= CMD_CLEAR;
      data_q        <= '0;
      rr_ptr_q      <= IDX_W'(N_REQ - 1);
      div_q         <= tick_period;
      tick_pend_q   <= 1'b0;
      evt_zero_q    <= 1'b0;
      evt_match_q   <= 1'b0;
      evt_wrap_q    <= 1'b0;
      evt_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      cmd_q         <= cmd_d;
      data_q        <= data_d;
      rr_ptr_q      <= rr_ptr_d;
      div_q         <= div_d;
      tick_pend_q   <= tick_pend_d;
      evt_zero_q    <= evt_zero_d;
      evt_match_q   <= evt_match_d;
      evt_wrap_q    <= evt_wrap_d;
      evt_overrun_q <= evt_overrun_d;
    end
  end

  assign count       = count_q;
  assign busy        = (state_q == ST_EXEC);
  assign evt_zero    = evt_zero_q;
  assign evt_match   = evt_match_q;
  assign evt_wrap    = evt_wrap_q;
  assign evt_overrun = evt_overrun_q;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Self-checking bench for counter_cmd_sequencer: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_counter_cmd_sequencer;

  localparam int N   = 2;
  localparam int W   = 8;
  localparam int DW  = 24;
  localparam int CW  = 2 * N;
  localparam int DTW = W * N;

  logic           sys_clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [N-1:0]   req_valid;
  logic [CW-1:0]  req_cmd;
  logic [DTW-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           autocount;
  logic [DW-1:0]  tick_period;
  logic [W-1:0]   match_value;
  logic [W-1:0]   count;
  logic           busy;
  logic           evt_zero;
  logic           evt_match;
  logic           evt_wrap;
  logic           evt_overrun;

  counter_cmd_sequencer #(.N_REQ(N), .WIDTH(W), .DIV_W(DW)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_cmd     (req_cmd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .autocount   (autocount),
    .tick_period (tick_period),
    .match_value (match_value),
    .count       (count),
    .busy        (busy),
    .evt_zero    (evt_zero),
    .evt_match   (evt_match),
    .evt_wrap    (evt_wrap),
    .evt_overrun (evt_overrun)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: counter value, whether a command is being executed,
  // the latched command, last winner, prescaler, pending tick, event pulses.
  bit m_known = 0;
  int m_count, m_exec, m_cmd, m_data, m_rr, m_div, m_pend;
  int m_ez, m_em, m_ew, m_eo;
  int last_grant;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check DUT against model, advance model, cross one posedge.
  task automatic cyc();
    int  g;
    bit  take, tick, ovr, new_pend;
    int  r, ew;
    #1;
    g    = -1;
    take = 0;
    if (!reset && enable && m_exec == 0) begin
      for (int i = 1; i <= N; i++) begin
        if (g < 0 && req_valid[(m_rr + i) % N]) g = (m_rr + i) % N;
      end
      if (g < 0 && m_pend != 0) take = 1;
    end
    if (m_known) begin
      check_eq("req_ready", 32'(req_ready), (g >= 0) ? (1 << g) : 0);
      check_eq("count", 32'(count), m_count);
      check_eq("busy", 32'(busy), m_exec);
      check_eq("evt_zero", 32'(evt_zero), m_ez);
      check_eq("evt_match", 32'(evt_match), m_em);
      check_eq("evt_wrap", 32'(evt_wrap), m_ew);
      check_eq("evt_overrun", 32'(evt_overrun), m_eo);
    end
    last_grant = g;
    if (reset) begin
      m_known = 1;
      m_count = 0; m_exec = 0; m_cmd = 0; m_data = 0; m_rr = N - 1;
      m_div = int'(tick_period); m_pend = 0;
      m_ez = 0; m_em = 0; m_ew = 0; m_eo = 0;
      last_grant = -1;
    end else begin
      tick     = (m_div == 0);
      ovr      = tick && autocount && m_pend != 0 && !take;
      new_pend = (m_pend != 0 && !take) || (tick && autocount);
      m_div    = tick ? int'(tick_period) : m_div - 1;
      m_ez = 0; m_em = 0; m_ew = 0;
      if (m_exec != 0) begin
        ew = 0;
        case (m_cmd)
          0: r = 0;
          1: r = m_data;
          2: begin r = (m_count + 1) % 256; ew = (m_count == 255); end
          default: begin r = (m_count + 255) % 256; ew = (m_count == 0); end
        endcase
`ifdef COUNT_SAT_EN
        if (ew != 0) r = m_count;
`endif
        m_count = r;
        m_ez    = (r == 0);
        m_em    = (r == int'(match_value));
        m_ew    = ew;
        m_exec  = 0;
      end else if (g >= 0) begin
        m_cmd  = (int'(req_cmd) >> (2 * g)) & 3;
        m_data = (int'(req_data) >> (W * g)) & 255;
        m_rr   = g;
        m_exec = 1;
      end else if (take) begin
        m_cmd  = 2;
        m_exec = 1;
      end
      m_pend = new_pend ? 1 : 0;
      m_eo   = ovr ? 1 : 0;
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic set_req(input int rq, input int cmd, input int data);
    req_cmd  = (req_cmd & ~(CW'(3) << (2 * rq))) | (CW'(cmd & 3) << (2 * rq));
    req_data = (req_data & ~(DTW'(255) << (W * rq))) | (DTW'(data & 255) << (W * rq));
    req_valid[rq] = 1'b1;
  endtask

  // Present a command and hold it until the model says it is accepted.
  task automatic issue(input int rq, input int cmd, input int data);
    bit done;
    done = 0;
    set_req(rq, cmd, data);
    for (int k = 0; k < 20 && !done; k++) begin
      cyc();
      if (last_grant == rq) done = 1;
    end
    if (!done) check_eq("issue_timeout", 0, 1);
    req_valid[rq] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  int ovr_seen;
  int sel;

  initial begin
    reset = 1'b1; enable = 1'b0; req_valid = '0; req_cmd = '0; req_data = '0;
    autocount = 1'b0; tick_period = DW'(3); match_value = '0;
    @(negedge sys_clk);

    // 1: auto-count only, one step every 4 cycles
    do_reset();
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_evt_zero", 32'(evt_zero), 0);
    enable = 1'b1; autocount = 1'b1;
    repeat (20) cyc();
    check_eq("t1_count", 32'(count), 4);

    // 2: both requesters hold UP, alternating grants
    autocount = 1'b0;
    do_reset();
    set_req(0, 2, 0);
    set_req(1, 2, 0);
    repeat (8) cyc();
    check_eq("t2_count", 32'(count), 4);
    req_valid = '0;
    cyc(); cyc();

    // 3: wrap from all-ones
    issue(0, 1, 8'hFF);
    cyc();
    issue(1, 2, 0);
    cyc();
`ifdef COUNT_SAT_EN
    check_eq("t3_count", 32'(count), 8'hFF);
    check_eq("t3_zero", 32'(evt_zero), 0);
`else
    check_eq("t3_count", 32'(count), 0);
    check_eq("t3_zero", 32'(evt_zero), 1);
`endif
    check_eq("t3_wrap", 32'(evt_wrap), 1);

    // 4: match pulse and DOWN from zero
    match_value = 8'h80;
    issue(0, 1, 8'h7F);
    cyc();
    issue(0, 2, 0);
    cyc();
    check_eq("t4_count", 32'(count), 8'h80);
    check_eq("t4_match", 32'(evt_match), 1);
    cyc();
    check_eq("t4_match_pulse", 32'(evt_match), 0);
    issue(1, 0, 0);
    cyc();
    issue(1, 3, 0);
    cyc();
`ifdef COUNT_SAT_EN
    check_eq("t4_down_count", 32'(count), 0);
`else
    check_eq("t4_down_count", 32'(count), 8'hFF);
`endif
    check_eq("t4_down_wrap", 32'(evt_wrap), 1);

    // 5: tick every cycle starved by a continuous requester
    tick_period = '0; autocount = 1'b1;
    do_reset();
    set_req(0, 2, 0);
    ovr_seen = 0;
    repeat (20) begin
      cyc();
      if (evt_overrun) ovr_seen++;
    end
    check_eq("t5_overrun_seen", 32'(ovr_seen > 10), 1);
    req_valid = '0;
    autocount = 1'b0;

    // 6: reset during EXEC, then enable low blocks grants
    tick_period = DW'(3);
    do_reset();
    issue(0, 1, 8'h55);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_eq("t6_count", 32'(count), 0);
    check_eq("t6_evt_zero", 32'(evt_zero), 0);
    enable = 1'b0;
    set_req(1, 2, 0);
    repeat (5) begin
      cyc();
      check_eq("t6_ready_dis", 32'(req_ready), 0);
    end
    enable = 1'b1;
    issue(1, 2, 0);
    cyc();
    check_eq("t6_count_after", 32'(count), 1);

    // 7: randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        tick_period = DW'($urandom_range(0, 6));
        autocount   = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 3);
        match_value = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h80 : (sel == 2) ? 8'hFF : W'($urandom);
      end
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 299) == 0);
      for (int q = 0; q < N; q++) begin
        if (!req_valid[q] && $urandom_range(0, 1) == 1) begin
          sel = $urandom_range(0, 3);
          set_req(q, $urandom_range(0, 3),
                  (sel == 0) ? 0 : (sel == 1) ? 255 : (sel == 2) ? 127 : $urandom_range(0, 255));
        end
      end
      cyc();
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
    end
    reset = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
